// File: rtl/matmul_sequencer_if.sv
// Byte-stream bundle for matmul_sequencer: operand input stream and result output stream.
// The master side produces operand bytes and consumes result bytes.
interface matmul_sequencer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/matmul_sequencer.sv
// Loads two operand bytes onto the 2x2-by-2x1 multiplier, waits out its latency,
// then returns the two 5-bit result rows as two output bytes.
module matmul_sequencer #(
  parameter int MULT_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  matmul_sequencer_if.slave   bus,
  output logic [7:0]          mat1,
  output logic [7:0]          mat2,
  input  logic [9:0]          mat_out,
  output logic                busy
);
  typedef enum logic [2:0] {LOAD_A, LOAD_B, WAIT, SEND_LO, SEND_HI} state_t;

  localparam logic [2:0] LAT = 3'(MULT_LATENCY);

  state_t     state_q, state_d;
  logic [7:0] mat1_q, mat1_d;
  logic [7:0] mat2_q, mat2_d;
  logic [9:0] res_q, res_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LOAD_A;
      mat1_q  <= 8'h00;
      mat2_q  <= 8'h00;
      res_q   <= 10'h000;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mat1_q  <= mat1_d;
      mat2_q  <= mat2_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake outputs depend on state only, never on the partner's valid/ready.
  always_comb begin
    state_d       = state_q;
    mat1_d        = mat1_q;
    mat2_d        = mat2_q;
    res_d         = res_q;
    cnt_d         = cnt_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = 8'h00;
    case (state_q)
      LOAD_A: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mat1_d  = bus.in_data;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          mat2_d  = {4'b0000, bus.in_data[3:0]};
          cnt_d   = 3'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Count edges until the multiplier output reflects the new operands.
        if (cnt_q == LAT) begin
          res_d   = mat_out;
          cnt_d   = 3'd0;
          state_d = SEND_LO;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      SEND_LO: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {3'b000, res_q[4:0]};
        if (bus.out_ready) state_d = SEND_HI;
      end
      SEND_HI: begin
        bus.out_valid = 1'b1;
        bus.out_data  = {3'b000, res_q[9:5]};
        if (bus.out_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  assign mat1 = mat1_q;
  assign mat2 = mat2_q;
  assign busy = (state_q != LOAD_A);
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer at latency 1 and 3, each with a pipelined multiplier model.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic sel3 = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  matmul_sequencer_if bus1 ();
  matmul_sequencer_if bus3 ();

  assign bus1.in_data   = in_data;
  assign bus1.in_valid  = in_valid & ~sel3;
  assign bus1.out_ready = out_ready;
  assign bus3.in_data   = in_data;
  assign bus3.in_valid  = in_valid & sel3;
  assign bus3.out_ready = out_ready;

  logic [7:0] m1_1, m2_1, m1_3, m2_3;
  logic [9:0] mo_1, mo_3a, mo_3b, mo_3c;
  logic busy1, busy3;

  matmul_sequencer #(.MULT_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave),
    .mat1(m1_1), .mat2(m2_1), .mat_out(mo_1), .busy(busy1)
  );

  matmul_sequencer #(.MULT_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave),
    .mat1(m1_3), .mat2(m2_3), .mat_out(mo_3c), .busy(busy3)
  );

  function automatic logic [9:0] mult(input logic [7:0] a, input logic [7:0] b);
    logic [4:0] r0, r1;
    r0 = 5'(a[1:0]) * 5'(b[1:0]) + 5'(a[3:2]) * 5'(b[3:2]);
    r1 = 5'(a[5:4]) * 5'(b[1:0]) + 5'(a[7:6]) * 5'(b[3:2]);
    return {r1, r0};
  endfunction

  always_ff @(posedge clk) begin
    mo_1  <= mult(m1_1, m2_1);
    mo_3a <= mult(m1_3, m2_3);
    mo_3b <= mo_3a;
    mo_3c <= mo_3b;
  end

  function automatic logic cur_in_ready();
    return sel3 ? bus3.in_ready : bus1.in_ready;
  endfunction
  function automatic logic cur_out_valid();
    return sel3 ? bus3.out_valid : bus1.out_valid;
  endfunction
  function automatic logic [7:0] cur_out_data();
    return sel3 ? bus3.out_data : bus1.out_data;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic send_byte(input logic [7:0] d);
    int n;
    logic acc;
    in_data = d;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = cur_in_ready();
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic recv_byte(output logic [7:0] d, output int waited);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (!cur_out_valid() && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!cur_out_valid()) check_eq("recv_timeout", 32'd0, 32'd1);
    d = cur_out_data();
    @(posedge clk);
    @(negedge clk);
    waited = n;
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!cur_out_valid() && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!cur_out_valid()) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [7:0] b;
    int w;

    // Reset state
    #2;
    check_eq("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    check_eq("rst_busy", 32'(busy1), 32'd0);
    check_eq("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    check_eq("rst_mat1", 32'(m1_1), 32'h00);
    check_eq("rst_mat2", 32'(m2_1), 32'h00);
    check_eq("rst_out_data", 32'(bus1.out_data), 32'h00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Normal frame
    out_ready = 1'b1;
    send_byte(8'hE7);
    check_eq("nf_mat1", 32'(m1_1), 32'hE7);
    check_eq("nf_busy_b", 32'(busy1), 32'd1);
    send_byte(8'h0B);
    check_eq("nf_mat2", 32'(m2_1), 32'h0B);
    check_eq("nf_in_ready_wait", 32'(bus1.in_ready), 32'd0);
    check_eq("nf_out_valid_wait", 32'(bus1.out_valid), 32'd0);
    recv_byte(b, w);
    check_eq("nf_lo", 32'(b), 32'h0B);
    check_eq("nf_latency", 32'(w), 32'd2);
    recv_byte(b, w);
    check_eq("nf_hi", 32'(b), 32'h0C);
    check_eq("nf_hi_wait", 32'(w), 32'd0);
    check_eq("nf_idle_busy", 32'(busy1), 32'd0);
    check_eq("nf_idle_ready", 32'(bus1.in_ready), 32'd1);

    // Maximum values and ignored upper nibble
    send_byte(8'hFF);
    send_byte(8'hFB);
    check_eq("mx_mat2", 32'(m2_1), 32'h0B);
    recv_byte(b, w);
    check_eq("mx_lo", 32'(b), 32'h0F);
    recv_byte(b, w);
    check_eq("mx_hi", 32'(b), 32'h0F);
    send_byte(8'hFF);
    send_byte(8'h0F);
    recv_byte(b, w);
    check_eq("mx18_lo", 32'(b), 32'h12);
    recv_byte(b, w);
    check_eq("mx18_hi", 32'(b), 32'h12);
    check_eq("retain_mat1", 32'(m1_1), 32'hFF);
    check_eq("retain_mat2", 32'(m2_1), 32'h0F);

    // Output back-pressure
    out_ready = 1'b0;
    send_byte(8'hE7);
    send_byte(8'h0B);
    wait_out_valid();
    for (int i = 0; i < 10; i++) begin
      check_eq("bp_data", 32'(bus1.out_data), 32'h0B);
      check_eq("bp_valid", 32'(bus1.out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(bus1.in_ready), 32'd0);
      @(negedge clk);
    end
    recv_byte(b, w);
    check_eq("bp_lo", 32'(b), 32'h0B);
    check_eq("bp_hi_in_ready", 32'(bus1.in_ready), 32'd0);
    recv_byte(b, w);
    check_eq("bp_hi", 32'(b), 32'h0C);
    check_eq("bp_done_ready", 32'(bus1.in_ready), 32'd1);

    // Input gaps and ignored input during WAIT
    send_byte(8'hE7);
    for (int i = 0; i < 5; i++) begin
      check_eq("gap_in_ready", 32'(bus1.in_ready), 32'd1);
      check_eq("gap_mat1", 32'(m1_1), 32'hE7);
      @(negedge clk);
    end
    send_byte(8'h0B);
    in_data = 8'hAA;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check_eq("gap_wait_ready", 32'(bus1.in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    recv_byte(b, w);
    check_eq("gap_lo", 32'(b), 32'h0B);
    recv_byte(b, w);
    check_eq("gap_hi", 32'(b), 32'h0C);
    check_eq("gap_mat1_kept", 32'(m1_1), 32'hE7);
    check_eq("gap_mat2_kept", 32'(m2_1), 32'h0B);

    // Asynchronous reset in SEND_LO
    out_ready = 1'b0;
    send_byte(8'hE7);
    send_byte(8'h0B);
    wait_out_valid();
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_out_valid", 32'(bus1.out_valid), 32'd0);
    check_eq("ar_busy", 32'(busy1), 32'd0);
    check_eq("ar_mat1", 32'(m1_1), 32'h00);
    check_eq("ar_mat2", 32'(m2_1), 32'h00);
    check_eq("ar_in_ready", 32'(bus1.in_ready), 32'd1);
    check_eq("ar_out_data", 32'(bus1.out_data), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    send_byte(8'h55);
    send_byte(8'h05);
    recv_byte(b, w);
    check_eq("ar_lo", 32'(b), 32'h02);
    recv_byte(b, w);
    check_eq("ar_hi", 32'(b), 32'h02);

    // Latency 3 instance
    sel3 = 1'b1;
    check_eq("l3_idle_ready", 32'(bus3.in_ready), 32'd1);
    send_byte(8'hE7);
    send_byte(8'h0B);
    check_eq("l3_mat2", 32'(m2_3), 32'h0B);
    recv_byte(b, w);
    check_eq("l3_lo", 32'(b), 32'h0B);
    check_eq("l3_latency", 32'(w), 32'd4);
    recv_byte(b, w);
    check_eq("l3_hi", 32'(b), 32'h0C);
    send_byte(8'hFF);
    send_byte(8'h0F);
    recv_byte(b, w);
    check_eq("l3_mx_lo", 32'(b), 32'h12);
    recv_byte(b, w);
    check_eq("l3_mx_hi", 32'(b), 32'h12);
    check_eq("l3_busy_end", 32'(busy3), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Byte-stream front/back end for the 2x2-by-2x1 matrix multiplier. Accepts operands as an 8-bit valid/ready stream and registers them onto the multiplier's `mat1`/`mat2` inputs. After the multiplier's fixed latency it captures the 10-bit `mat_out` and returns the two 5-bit result rows as two bytes on an 8-bit valid/ready output stream. Sits between the chip I/O adapter and the multiplier core.

## Interface

Parameters:
- `MULT_LATENCY`, default 1: multiplier register stages from operand change to valid `mat_out`. Legal range 1..7.

Ports:
- `clk`, input, 1: single clock; all state is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_data`, input, 8: operand byte.
- `in_valid`, input, 1: `in_data` is valid.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `mat1`, output, 8: registered matrix operand to the multiplier. Entries are [1:0]=a00, [3:2]=a01, [5:4]=a10, [7:6]=a11.
- `mat2`, output, 8: registered vector operand to the multiplier. [1:0]=b0, [3:2]=b1, and [7:4] are always 0.
- `mat_out`, input, 10: multiplier result. [4:0]=row0, [9:5]=row1.
- `out_data`, output, 8: result byte.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: the downstream side accepts `out_data`.
- `busy`, output, 1: high in every state except LOAD_A.

## Operation

- States: LOAD_A, LOAD_B, WAIT, SEND_LO, SEND_HI. The reset state is LOAD_A.
- LOAD_A:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: `mat1`<=`in_data` and the state goes to LOAD_B.
- LOAD_B:
  - `in_ready`=1.
  - On a handshake: `mat2`<={4'b0, `in_data`[3:0]}. `in_data`[7:4] is ignored.
  - Wait counter <= 0. The state goes to WAIT.
- WAIT:
  - `in_ready`=0.
  - The counter increments each cycle.
  - When the counter equals `MULT_LATENCY`, that edge does three things: result register <= `mat_out`, state <= SEND_LO, counter cleared.
- SEND_LO:
  - `out_valid`=1 and `out_data`={3'b000, result[4:0]}.
  - On `out_ready`: the state goes to SEND_HI.
- SEND_HI:
  - `out_valid`=1 and `out_data`={3'b000, result[9:5]}.
  - On `out_ready`: the state goes to LOAD_A.
- Operand retention:
  - `mat1` and `mat2` hold their values until they are overwritten by the next frame.
  - The block never clears them between frames.
- Width rules:
  - Each result row is 5 bits unsigned, with a maximum of 3*3+3*3=18.
  - The block does no arithmetic; it only transports the result.
- `out_valid` must not depend combinationally on `out_ready`.
- `in_ready` must not depend combinationally on `in_valid`.
- In WAIT, `out_valid`=0. `in_valid` is ignored; no byte is consumed.
- Reset (asserted at any time, including mid-frame or mid-send):
  - State goes to LOAD_A immediately.
  - `mat1`, `mat2`, the result register, `out_data` and the counter all go to 0.
  - `out_valid`=0, `busy`=0, `in_ready`=1 while reset is released.
  - Any partial frame or unsent result is discarded.
- The multiplier's own reset is driven externally. This block does not gate it.

## Timing

- The operand B handshake is at edge E0.
  - `mat2` is updated at E0.
  - The multiplier samples it `MULT_LATENCY` edges later.
  - The result is captured at edge E0+`MULT_LATENCY`+1.
- `out_valid` first rises in the cycle after the capture edge. This is `MULT_LATENCY`+1 cycles after E0.
- With default latency and `out_ready` held at 1, one frame takes 6 cycles:
  - A accepted at E0-1 and B accepted at E0.
  - WAIT for 2 cycles.
  - LO byte sent at E0+3 and HI byte sent at E0+4.
  - Back in LOAD_A from E0+4, with `in_ready`=1.
- Back-pressure:
  - `out_valid` and `out_data` stay stable while `out_ready`=0, for any length of time.
  - The result register does not change.
- Input gaps:
  - Idle cycles between bytes (`in_valid`=0) stall in LOAD_A or LOAD_B with no side effects.

## Test plan

- **Normal frame.** Reset, then send 0xE7 then 0x0B with `out_ready`=1.
  - `mat1`=0xE7 and `mat2`=0x0B.
  - Output bytes are 0x0B then 0x0C.
  - `out_valid` first rises 2 cycles after the B accept.
- **Maximum values and ignored nibble.** Send 0xFF then 0xFB.
  - `mat2`=0x0B.
  - Results are row0=3*3+3*2=15 and row1=15, so the output bytes are 0x0F then 0x0F.
  - A second frame sending 0xFF then 0x0F gives 0x12 then 0x12.
- **Output back-pressure.** Hold `out_ready`=0 for 10 cycles in SEND_LO, then pulse it.
  - `out_data` stays 0x0B throughout the stall.
  - HI byte 0x0C follows.
  - `in_ready` stays 0 until the HI byte is accepted.
- **Input gaps.** Wait 5 idle cycles between A and B. Drive `in_valid`=1 during WAIT.
  - No extra byte is consumed.
  - Results are the same as in the normal frame.
- **Reset mid-operation.** Assert `reset` asynchronously between clock edges while in SEND_LO.
  - `out_valid`=0, `busy`=0, `mat1`=`mat2`=0 are seen before the next edge.
  - After release, a fresh frame 0x55, 0x05 gives row0=1*1+1*1=2 and row1=2, so the output bytes are 0x02 then 0x02.
- **Latency parameter.** With `MULT_LATENCY`=3 and a matching multiplier model:
  - `out_valid` rises 4 cycles after the B accept.
  - Values are correct.
